// File: rtl/rom_arbiter.sv
// ============================================================================
// Module      : rom_arbiter
// Description : Shares one synchronous ROM among NUM_REQ voices, one grant per
//               cycle, pipelined read return. Round-robin by default; define
//               ROM_ARBITER_FIXED_PRIO_EN for lowest-index-wins priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
   output logic [NUM_REQ-1:0]        o_ack,
   output logic [NUM_REQ-1:0]        o_data_valid,
   output logic [DATA_W-1:0]         o_data,
   output logic [ADDR_W-1:0]         o_rom_addr,
   input  logic [DATA_W-1:0]         i_rom_data
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W-1:0] C_LAST = PTR_W'(NUM_REQ - 1);

   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [NUM_REQ-1:0] valid_q, valid_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0] eligible;
   logic [PTR_W-1:0]   winner;
   logic [PTR_W-1:0]   cand;
   logic               found;

   always_comb begin
      // A voice whose ack is on this cycle is masked so its held request
      // does not win twice for the same transaction.
      eligible = i_req & ~ack_q;
      found    = 1'b0;
      winner   = '0;
      cand     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end

      ack_d = '0;
      if (found) begin
         ack_d[winner] = 1'b1;
      end

      rom_addr_d = found ? i_addr[int'(winner)*ADDR_W +: ADDR_W] : rom_addr_q;

      // ROM answers one cycle after the address registers with the ack.
      valid_d = ack_q;
      data_d  = (|valid_q) ? i_rom_data : data_q;

`ifdef ROM_ARBITER_FIXED_PRIO_EN
      rr_ptr_d = '0;
`else
      if (found) begin
         rr_ptr_d = (winner == C_LAST) ? '0 : winner + PTR_W'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack_q      <= '0;
         valid_q    <= '0;
         data_q     <= '0;
         rom_addr_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         ack_q      <= ack_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         rom_addr_q <= rom_addr_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign o_ack        = ack_q;
   assign o_data_valid = valid_q;
   assign o_data       = data_d;
   assign o_rom_addr   = rom_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Directed self-checking bench for rom_arbiter with a 1-cycle
//               synchronous ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [19:0] addr;
   logic [3:0]  ack;
   logic [3:0]  dval;
   logic [15:0] data;
   logic [4:0]  rom_addr;
   logic [15:0] rom_q;
   logic [15:0] rom [32];

   int errors = 0;
   int checks = 0;

   rom_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(16)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req        (req),
      .i_addr       (addr),
      .o_ack        (ack),
      .o_data_valid (dval),
      .o_data       (data),
      .o_rom_addr   (rom_addr),
      .i_rom_data   (rom_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= rom[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      step();
      rst_n = 1'b1;
   endtask

   logic [3:0]  exp_ack [6];
   logic [3:0]  exp_val [6];
   logic [15:0] exp_dat [6];

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i) * 16'h0101;
      rom[7] = 16'hBEEF;
      rom_q  = '0;
      rst_n  = 1'b0;
      req    = '0;
      addr   = '0;

      // Reset state
      step();
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_dval", 32'(dval), 32'h0);
      chk("rst_data", 32'(data), 32'h0);
      chk("rst_addr", 32'(rom_addr), 32'h0);
      rst_n = 1'b1;

      // Single request on voice 2, address 7
      req  = 4'b0100;
      addr = {5'd0, 5'h07, 5'd0, 5'd0};
      step();
      chk("single_ack", 32'(ack), 32'h4);
      chk("single_addr", 32'(rom_addr), 32'h7);
      req = '0;
      step();
      chk("single_dval", 32'(dval), 32'h4);
      chk("single_data", 32'(data), 32'hBEEF);
      chk("single_ack_off", 32'(ack), 32'h0);
      step();
      chk("single_dval_off", 32'(dval), 32'h0);
      chk("single_data_hold", 32'(data), 32'hBEEF);
      chk("single_addr_hold", 32'(rom_addr), 32'h7);

      // All voices requesting, addresses 1..4
      do_reset();
      req  = 4'b1111;
      addr = {5'd4, 5'd3, 5'd2, 5'd1};
`ifdef ROM_ARBITER_FIXED_PRIO_EN
      exp_ack = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
      exp_val = '{4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
      exp_dat = '{16'h0000, 16'h1101, 16'h1202, 16'h1101, 16'h1202, 16'h1101};
`else
      exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      exp_val = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_dat = '{16'h0000, 16'h1101, 16'h1202, 16'h1303, 16'h1404, 16'h1101};
`endif
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("all_ack%0d", k), 32'(ack), 32'(exp_ack[k]));
         chk($sformatf("all_dval%0d", k), 32'(dval), 32'(exp_val[k]));
         chk($sformatf("all_data%0d", k), 32'(data), 32'(exp_dat[k]));
      end
      req = '0;

      // Voice 0 holding its request: grant every second cycle
      do_reset();
      req  = 4'b0001;
      addr = {5'd0, 5'd0, 5'd0, 5'd3};
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("hold_ack%0d", k), 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("hold_dval%0d", k), 32'(dval), (k % 2 == 1) ? 32'h1 : 32'h0);
      end
      req = '0;

      // Voices 1 and 3: round-robin fairness after voice 1 wins
      do_reset();
      req  = 4'b1010;
      addr = {5'd9, 5'd0, 5'd8, 5'd0};
      step();
      chk("rr_first_ack", 32'(ack), 32'h2);
      req = '0;
      step();
      chk("rr_idle_ack", 32'(ack), 32'h0);
      req = 4'b1010;
      step();
`ifdef ROM_ARBITER_FIXED_PRIO_EN
      chk("rr_second_ack", 32'(ack), 32'h2);
      chk("rr_second_addr", 32'(rom_addr), 32'h8);
`else
      chk("rr_second_ack", 32'(ack), 32'h8);
      chk("rr_second_addr", 32'(rom_addr), 32'h9);
`endif
      req = '0;

      // Asynchronous reset the cycle after an ack
      do_reset();
      req  = 4'b0001;
      addr = {5'd0, 5'd0, 5'd0, 5'd5};
      step();
      chk("arst_pre_ack", 32'(ack), 32'h1);
      req = '0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_ack", 32'(ack), 32'h0);
      chk("arst_addr", 32'(rom_addr), 32'h0);
      chk("arst_dval", 32'(dval), 32'h0);
      chk("arst_data", 32'(data), 32'h0);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk($sformatf("arst_post_dval%0d", k), 32'(dval), 32'h0);
         chk($sformatf("arst_post_data%0d", k), 32'(data), 32'h0);
      end

      // Voice 3 raises then drops while voice 0 wins
      do_reset();
      req  = 4'b1001;
      addr = {5'd11, 5'd0, 5'd0, 5'd6};
      step();
      chk("drop_ack0", 32'(ack), 32'h1);
      chk("drop_addr0", 32'(rom_addr), 32'h6);
      req = 4'b0001;
      for (int k = 1; k < 5; k++) begin
         step();
         chk($sformatf("drop_ack%0d", k), 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("drop_dval%0d", k), 32'(dval), (k % 2 == 1) ? 32'h1 : 32'h0);
         chk($sformatf("drop_addr%0d", k), 32'(rom_addr), 32'h6);
      end
      req = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
